// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC register, next-PC selection and fetch bookkeeping for the
// single-cycle MIPS datapath.
//
// Holds the PC, selects the next PC from sequential / branch / jump / jump-register
// paths (priority jump_reg > jump > branch_taken > sequential), honours stall,
// halts on the all-zero instruction and counts accepted instructions.
//
// Optional feature (macro FETCH_RAS_EN): RAS_DEPTH-entry circular return-address
// stack. JAL pushes pc+4, JR $ra pops it when the stack is non-empty.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   stall                 hold PC, state and counters this cycle
//   branch_taken/imm      PC-relative branch, signed word offset
//   jump/jump_link/index  J/JAL with 26-bit target field
//   jump_reg/ret/addr     JR (JR $ra when jump_ret) with register target
//   inst_in               instruction read at pc
//   pc, pc_plus4          current PC and its link value
//   inst_out, inst_valid  instruction to decode and its valid flag
//   halted                sequencer stopped on a zero instruction
//   misaligned            sticky: JR target had nonzero low bits
//   fetch_count           saturating count of accepted instructions
//   ras_overflow          sticky: push onto a full return-address stack
module fetch_sequencer #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [15:0]       branch_imm,
    input  logic              jump,
    input  logic              jump_link,
    input  logic [25:0]       jump_index,
    input  logic              jump_reg,
    input  logic              jump_ret,
    input  logic [ADDR_W-1:0] jump_reg_addr,
    input  logic [DATA_W-1:0] inst_in,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [DATA_W-1:0] inst_out,
    output logic              inst_valid,
    output logic              halted,
    output logic              misaligned,
    output logic [CNT_W-1:0]  fetch_count,
    output logic              ras_overflow
);

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);
    // Bits replaced by the J-format target; upper bits come from pc+4.
    localparam logic [ADDR_W-1:0] JumpMask = ADDR_W'(28'hFFF_FFFF);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mis_q, mis_d;

    logic               run_ok, nonzero, accept;
    logic [ADDR_W-1:0]  jr_tgt, j_tgt, br_tgt, br_off;
    logic               ras_hit, ras_push, ras_pop;
    logic [ADDR_W-1:0]  ras_top;

    assign nonzero    = |inst_in;
    assign run_ok     = (state_q == StRun) && !stall;
    assign accept     = run_ok && nonzero;

    assign pc          = pc_q;
    assign pc_plus4    = pc_q + ADDR_W'(4);
    assign inst_out    = inst_in;
    assign inst_valid  = accept && !reset;
    assign halted      = (state_q == StHalted);
    assign misaligned  = mis_q;
    assign fetch_count = cnt_q;

    assign jr_tgt = {jump_reg_addr[ADDR_W-1:2], 2'b00};
    assign j_tgt  = (pc_plus4 & ~JumpMask) | ADDR_W'({jump_index, 2'b00});
    assign br_off = {{(ADDR_W-18){branch_imm[15]}}, branch_imm, 2'b00};
    assign br_tgt = pc_plus4 + br_off;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        mis_d    = mis_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (run_ok) begin
            if (!nonzero) begin
                state_d = StHalted;
            end else begin
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                if (jump_reg) begin
                    if (ras_hit) begin
                        pc_d    = ras_top;
                        ras_pop = 1'b1;
                    end else begin
                        pc_d = jr_tgt;
                        if (|jump_reg_addr[1:0]) mis_d = 1'b1;
                    end
                end else if (jump) begin
                    pc_d     = j_tgt;
                    ras_push = jump_link;
                end else if (branch_taken) begin
                    pc_d = br_tgt;
                end else begin
                    pc_d = pc_plus4;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
            pc_q    <= ResetPc;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

`ifdef FETCH_RAS_EN
    localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];
    logic [PtrW-1:0]   ras_sp_q;   // next slot to write; top of stack is sp-1
    logic [PtrW:0]     ras_cnt_q;
    logic              ras_ovf_q;

    assign ras_hit      = jump_ret && (ras_cnt_q != '0);
    assign ras_top      = ras_mem_q[ras_sp_q - PtrW'(1)];
    assign ras_overflow = ras_ovf_q;

    // Circular: a push when full lands on the oldest entry and the depth stays full.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(RAS_DEPTH); i++) ras_mem_q[i] <= '0;
            ras_sp_q  <= '0;
            ras_cnt_q <= '0;
            ras_ovf_q <= 1'b0;
        end else if (ras_push) begin
            ras_mem_q[ras_sp_q] <= pc_plus4;
            ras_sp_q            <= ras_sp_q + PtrW'(1);
            if (ras_cnt_q == (PtrW + 1)'(RAS_DEPTH)) ras_ovf_q <= 1'b1;
            else                                     ras_cnt_q <= ras_cnt_q + (PtrW + 1)'(1);
        end else if (ras_pop) begin
            ras_sp_q  <= ras_sp_q - PtrW'(1);
            ras_cnt_q <= ras_cnt_q - (PtrW + 1)'(1);
        end
    end
`else
    logic unused_ras;

    assign ras_hit      = 1'b0;
    assign ras_top      = '0;
    assign ras_overflow = 1'b0;
    assign unused_ras   = ^{jump_ret, ras_push, ras_pop, RAS_DEPTH[0]};
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;   // small counter so saturation is reachable

`ifdef FETCH_RAS_EN
    localparam bit RasOn = 1'b1;
`else
    localparam bit RasOn = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          stall = 1'b0;
    logic          branch_taken = 1'b0;
    logic [15:0]   branch_imm = '0;
    logic          jump = 1'b0;
    logic          jump_link = 1'b0;
    logic [25:0]   jump_index = '0;
    logic          jump_reg = 1'b0;
    logic          jump_ret = 1'b0;
    logic [AW-1:0] jump_reg_addr = '0;
    logic [DW-1:0] inst_in = 32'h2402_0001;

    logic [AW-1:0] pc, pc_plus4;
    logic [DW-1:0] inst_out;
    logic          inst_valid, halted, misaligned, ras_overflow;
    logic [CW-1:0] fetch_count;

    fetch_sequencer #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .RESET_PC  (32'h0040_0000),
        .CNT_W     (CW),
        .RAS_DEPTH (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_imm    (branch_imm),
        .jump          (jump),
        .jump_link     (jump_link),
        .jump_index    (jump_index),
        .jump_reg      (jump_reg),
        .jump_ret      (jump_ret),
        .jump_reg_addr (jump_reg_addr),
        .inst_in       (inst_in),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .inst_out      (inst_out),
        .inst_valid    (inst_valid),
        .halted        (halted),
        .misaligned    (misaligned),
        .fetch_count   (fetch_count),
        .ras_overflow  (ras_overflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected PC pushed when a cycle's stimulus is applied.
    logic [AW-1:0] exp_pc_q [$];
    string         tag_q    [$];
    logic [CW-1:0] exp_cnt = '0;
    logic          exp_halt = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_redirects();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_imm    = '0;
        jump          = 1'b0;
        jump_link     = 1'b0;
        jump_index    = '0;
        jump_reg      = 1'b0;
        jump_ret      = 1'b0;
        jump_reg_addr = '0;
        inst_in       = 32'h2402_0001;
    endtask

    // Apply current inputs for one clock and compare the resulting state.
    task automatic step(input string tag, input logic [AW-1:0] exp_pc);
        string t;
        exp_pc_q.push_back(exp_pc);
        tag_q.push_back(tag);
        if (!stall && !exp_halt) begin
            if (inst_in == '0) exp_halt = 1'b1;
            else if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        end
        @(posedge clock);
        #1;
        t = tag_q.pop_front();
        check_eq({t, "/pc"}, pc, exp_pc_q.pop_front());
        check_eq({t, "/halted"}, halted, exp_halt);
        check_eq({t, "/count"}, fetch_count, exp_cnt);
    endtask

    // Asynchronous reset pulse mid-cycle; effects must show before any edge.
    task automatic do_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        check_eq({tag, "/pc"}, pc, 32'h0040_0000);
        check_eq({tag, "/halted"}, halted, 1'b0);
        check_eq({tag, "/valid"}, inst_valid, 1'b0);
        check_eq({tag, "/count"}, fetch_count, 0);
        check_eq({tag, "/mis"}, misaligned, 1'b0);
        check_eq({tag, "/ovf"}, ras_overflow, 1'b0);
        exp_cnt  = '0;
        exp_halt = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        clear_redirects();
    endtask

    initial begin
        logic [AW-1:0] e;

        repeat (2) @(posedge clock);
        #1;
        check_eq("rst/pc", pc, 32'h0040_0000);
        check_eq("rst/valid", inst_valid, 1'b0);
        check_eq("rst/count", fetch_count, 0);
        check_eq("rst/halted", halted, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        #1;

        // Sequential fetch of three words then halt on zero.
        check_eq("seq/valid", inst_valid, 1'b1);
        check_eq("seq/inst_out", inst_out, 32'h2402_0001);
        step("seq0", 32'h0040_0004);
        step("seq1", 32'h0040_0008);
        step("seq2", 32'h0040_000C);
        inst_in = '0;
        #1 check_eq("zero/valid", inst_valid, 1'b0);
        step("halt", 32'h0040_000C);
        check_eq("halt/cnt3", fetch_count, 3);
        inst_in    = 32'h0800_0000;
        jump       = 1'b1;
        jump_index = 26'h010_0004;
        #1 check_eq("halt/valid", inst_valid, 1'b0);
        step("halt_hold", 32'h0040_000C);

        // Async reset while halted.
        do_reset("rst_halt");

        // Jump beats branch.
        jump         = 1'b1;
        jump_index   = 26'h010_0004;
        branch_taken = 1'b1;
        branch_imm   = 16'h0005;
        step("jump", 32'h0040_0010);
        clear_redirects();

        // Stall holds everything, then backward branch.
        stall        = 1'b1;
        branch_taken = 1'b1;
        branch_imm   = 16'hFFFC;
        for (int i = 0; i < 3; i++) begin
            #1 check_eq("stall/valid", inst_valid, 1'b0);
            step("stall", 32'h0040_0010);
        end
        stall = 1'b0;
        step("branch_back", 32'h0040_0004);
        clear_redirects();

        // Misaligned JR wins over jump; sticky across later fetches.
        jump_reg      = 1'b1;
        jump          = 1'b1;
        jump_index    = 26'h000_0001;
        jump_reg_addr = 32'h0040_0023;
        step("jr_mis", 32'h0040_0020);
        check_eq("jr_mis/flag", misaligned, 1'b1);
        clear_redirects();
        step("seq_after_jr", 32'h0040_0024);
        branch_taken = 1'b1;
        branch_imm   = 16'h0003;
        step("branch_fwd", 32'h0040_0034);
        check_eq("mis_sticky", misaligned, 1'b1);
        clear_redirects();

        // Top-of-address-space wrap.
        jump_reg      = 1'b1;
        jump_reg_addr = 32'hFFFF_FFFC;
        step("jr_top", 32'hFFFF_FFFC);
        check_eq("wrap/pc_plus4", pc_plus4, 0);
        clear_redirects();
        step("wrap", 32'h0000_0000);

        do_reset("rst_mis");

        // Return-address stack (or plain JR when the stack is absent).
        jump       = 1'b1;
        jump_link  = 1'b1;
        jump_index = 26'h010_0040;
        step("jal", 32'h0040_0100);
        clear_redirects();
        jump_reg      = 1'b1;
        jump_ret      = 1'b1;
        jump_reg_addr = 32'h0040_0040;
        step("jr_ra", RasOn ? 32'h0040_0004 : 32'h0040_0040);
        clear_redirects();
        for (int i = 0; i < 5; i++) begin
            jump       = 1'b1;
            jump_link  = 1'b1;
            jump_index = 26'h010_0080;
            step("jal_nest", 32'h0040_0200);
            if (i == 3) check_eq("ras_not_ovf", ras_overflow, 1'b0);
        end
        check_eq("ras_ovf", ras_overflow, RasOn);
        clear_redirects();
        for (int i = 0; i < 5; i++) begin
            jump_reg      = 1'b1;
            jump_ret      = 1'b1;
            jump_reg_addr = 32'h0040_0300;
            step("jr_pop", (RasOn && i < 4) ? 32'h0040_0204 : 32'h0040_0300);
        end
        clear_redirects();

        // Run past the counter ceiling.
        e = 32'h0040_0300;
        for (int i = 0; i < 6; i++) begin
            e = e + 32'd4;
            step("sat", e);
        end
        check_eq("cnt_sat", fetch_count, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Parametrised PC/fetch sequencer for the single-cycle MIPS datapath.
- Replaces the fixed PC register, add-4 adder and jump mux with one block.
- Holds the PC and selects the next PC from sequential, branch, jump and jump-register paths, with stall support.
- Detects the all-zero halt instruction, counts fetched instructions, and optionally predicts returns with a return-address stack.

Parameters:
ADDR_W, 32, PC/address width (>=28)
DATA_W, 32, instruction width
RESET_PC, 32'h00400000, PC value loaded on reset (truncated to ADDR_W)
CNT_W, 16, fetch counter width
RAS_DEPTH, 4, return-address stack entries (power of 2, used only with FETCH_RAS_EN)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
stall  in  1  hold PC and state this cycle
branch_taken  in  1  take PC-relative branch
branch_imm  in  16  branch immediate (word offset, signed)
jump  in  1  J/JAL taken
jump_link  in  1  with jump: JAL (push return address)
jump_index  in  26  J-format target field
jump_reg  in  1  JR taken
jump_ret  in  1  with jump_reg: JR $ra (pop RAS)
jump_reg_addr  in  ADDR_W  register-file target for JR
inst_in  in  DATA_W  instruction read at pc
pc  out  ADDR_W  current PC
pc_plus4  out  ADDR_W  pc+4 (link value)
inst_out  out  DATA_W  instruction passed to decode
inst_valid  out  1  inst_out valid this cycle
halted  out  1  sequencer in HALTED state
misaligned  out  1  sticky: JR target had nonzero bits [1:0]
fetch_count  out  CNT_W  number of instructions accepted
ras_overflow  out  1  sticky: push onto full RAS

Behaviour:
- Reset (async, any time, including mid-stall or mid-halt):
  - pc=RESET_PC, state=RUN.
  - fetch_count=0, misaligned=0, ras_overflow=0, RAS empty.
  - inst_valid=0 while reset is asserted.
- Combinational outputs:
  - pc_plus4 = pc+4, modulo 2^ADDR_W (wraps to 0 at the top of the address space).
  - inst_out = inst_in.
  - inst_valid = (state==RUN) & ~stall & ~reset & (inst_in!=0).
- FSM:
  - RUN -> HALTED when state==RUN, ~stall and inst_in==0.
  - HALTED holds until reset. pc frozen, inst_valid=0, all redirect inputs ignored.
- Next PC, evaluated at each rising edge in RUN with ~stall and inst_in!=0. Priority when redirect inputs are asserted together: jump_reg > jump > branch_taken > sequential.
  - jump_reg: target = {jump_reg_addr[ADDR_W-1:2],2'b00}. If jump_reg_addr[1:0]!=0, set misaligned (sticky until reset).
  - jump: target = {pc_plus4[ADDR_W-1:28], jump_index, 2'b00}.
  - branch: target = pc_plus4 + (sign_extend(branch_imm)<<2), modulo 2^ADDR_W.
  - Otherwise: target = pc_plus4.
- Stall: pc, state and counters hold. Redirect inputs ignored. inst_valid=0.
- fetch_count increments by 1 on every cycle with inst_valid=1. It saturates at all-ones and does not wrap.
- Latency:
  - A redirect applied in cycle N is visible on pc in cycle N+1.
  - A single-cycle fetch gives no bubble.

Optional Feature:
Macro FETCH_RAS_EN.
- Defined:
  - Adds a RAS_DEPTH-entry circular stack.
  - Accepted jump & jump_link pushes pc_plus4. A push when full overwrites the oldest entry and sets ras_overflow (sticky).
  - Accepted jump_reg & jump_ret with a non-empty RAS: pops, and the target is the popped value; jump_reg_addr is ignored.
  - Pop on empty RAS falls back to jump_reg_addr.
  - Push and pop cannot coincide because priority makes them exclusive.
- Undefined:
  - No stack is instantiated.
  - jump_ret is ignored; JR always uses jump_reg_addr.
  - ras_overflow is tied to 0.

Test Plan:
1. Reset release, memory 3 nonzero words then 0 -> pc 00400000, 00400004, 00400008, 0040000C; halted=1 in the cycle after pc=0040000C; fetch_count=3; pc stays 0040000C.
2. At pc=00400000, jump with jump_index=0x0100004 -> next pc=00400010. Assert jump and branch_taken together -> jump wins.
3. At pc=00400010, branch_imm=16'hFFFC with branch_taken -> next pc=00400004. With stall held 3 cycles -> pc stays 00400010 and fetch_count unchanged.
4. jump_reg with jump_reg_addr=00400023 -> pc=00400020, misaligned=1. misaligned stays 1 until reset pulse, then clears with pc=00400000.
5. FETCH_RAS_EN, RAS_DEPTH=4:
   - JAL from 00400000 -> pushes 00400004.
   - Later JR $ra with jump_reg_addr=0 -> pc=00400004.
   - 5 nested JALs -> ras_overflow=1.
6. Reset asserted asynchronously while HALTED -> halted=0, pc=00400000 immediately, without a clock edge.
